half_sub_bist: RTL

HALF_SUB_BIST -- requirements
Module: half_sub_bist

---
 rtl/half_sub_bist.sv | 124 ++++++++++++
 1 files changed

// File: rtl/half_sub_bist.sv
// Built-in self test for an external half subtractor.
// Walks {a,b} through 00,01,10,11 per pass and counts bad results.
module half_sub_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             barrow,
    input  logic             diff,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [1:0]       first_fail_vec
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      vec;
    logic [SW-1:0]   settle;
    logic [LW-1:0]   loop_cnt;
    logic            mis;
    logic            exp_diff;
    logic            exp_barrow;

    // a/b come straight from the registered vector index
    assign a = vec[1];
    assign b = vec[0];

    assign exp_diff   = vec[1] ^ vec[0];
    assign exp_barrow = ~vec[1] & vec[0];
    assign mis        = (diff != exp_diff) | (barrow != exp_barrow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= 2'b00;
            settle         <= '0;
            loop_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= 2'b00;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= DRIVE;
                        busy           <= 1'b1;
                        vec            <= 2'b00;
                        settle         <= '0;
                        loop_cnt       <= '0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        fail_seen      <= 1'b0;
                        first_fail_vec <= 2'b00;
                    end
                end
                DRIVE: begin
                    if (settle == SETTLE_LAST) begin
                        state  <= CHECK;
                        settle <= '0;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                CHECK: begin
                    if (mis) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        fail_seen <= 1'b1;
                        if (!fail_seen) begin
                            first_fail_vec <= vec;
                        end
                    end
                    if (vec == 2'b11) begin
                        vec <= 2'b00;
                        if (loop_cnt == LOOP_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // err_cnt never wraps, so "no mismatch ever" is exact
                            pass  <= ~(fail_seen | mis);
                        end else begin
                            state    <= DRIVE;
                            loop_cnt <= loop_cnt + 1'b1;
                        end
                    end else begin
                        state <= DRIVE;
                        vec   <= vec + 2'b01;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
